// File: rtl/arb_pkg.sv
// Shared sizing and FSM state encoding for the round-robin index arbiter.
package arb_pkg;
    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;
endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: first set request bit at or after ptr, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = arb_pkg::NUM_REQ,
    parameter int IDX_W   = arb_pkg::IDX_W
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);
    import arb_pkg::*;

    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is the one kept.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter presenting a registered winner index with a valid/ready handshake.
//   state | meaning
//   IDLE  | no grant outstanding, grant_valid low
//   GRANT | grant_idx valid, holding until grant_ready
module rr_index_arbiter #(
    parameter int NUM_REQ = arb_pkg::NUM_REQ,
    parameter int IDX_W   = arb_pkg::IDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               grant_ready,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic [IDX_W-1:0]   ptr
);
    import arb_pkg::*;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] search_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             handshake;

    assign handshake = (state_q == GRANT) && grant_ready;

    // On handshake the next winner is searched from the already-advanced pointer.
    assign search_ptr = handshake ? (idx_q + IDX_W'(1)) : ptr_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (search_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    idx_d   = pick_idx;
                end
            end
            GRANT: begin
                if (handshake) begin
                    ptr_d = search_ptr;
                    if (pick_found) begin
                        idx_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    assign grant_valid = (state_q == GRANT);
    assign grant_idx   = idx_q;
    assign ptr         = ptr_q;
endmodule

// File: tb/tb_rr_index_arbiter.sv
// Directed self-checking bench for rr_index_arbiter.
module tb_rr_index_arbiter;
    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       grant_ready;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic [2:0] ptr;

    int total  = 0;
    int passed = 0;

    rr_index_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant_ready (grant_ready),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .ptr         (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] exp_idx;
        logic [7:0] seen;
        logic [7:0] onehot;
        logic       rdy;
        int         hs;
        int         cyc;

        rst = 1'b1;
        req = 8'h00;
        grant_ready = 1'b0;
        #3;
        chk("rst_valid", 32'(grant_valid), 0);
        chk("rst_idx",   32'(grant_idx), 0);
        chk("rst_ptr",   32'(ptr), 0);
        step();
        step();
        rst = 1'b0;

        // Idle with no requests; grant_ready in the later cycles must be ignored.
        for (int i = 0; i < 10; i++) begin
            if (i >= 5) grant_ready = 1'b1;
            step();
            chk("idle_valid", 32'(grant_valid), 0);
        end
        chk("idle_idx", 32'(grant_idx), 0);
        chk("idle_ptr", 32'(ptr), 0);

        // Back-to-back rotation over bits 2,5,7.
        req = 8'b1010_0100;
        grant_ready = 1'b1;
        step(); chk("b2b_idx0", 32'(grant_idx), 2); chk("b2b_v0", 32'(grant_valid), 1); chk("b2b_p0", 32'(ptr), 0);
        step(); chk("b2b_idx1", 32'(grant_idx), 5); chk("b2b_v1", 32'(grant_valid), 1); chk("b2b_p1", 32'(ptr), 3);
        step(); chk("b2b_idx2", 32'(grant_idx), 7); chk("b2b_v2", 32'(grant_valid), 1); chk("b2b_p2", 32'(ptr), 6);
        step(); chk("b2b_idx3", 32'(grant_idx), 2); chk("b2b_v3", 32'(grant_valid), 1); chk("b2b_p3", 32'(ptr), 0);
        req = 8'h00;
        step(); chk("b2b_end_v", 32'(grant_valid), 0); chk("b2b_end_p", 32'(ptr), 3); chk("b2b_end_idx", 32'(grant_idx), 2);

        // Stall with request withdrawn: no retraction.
        grant_ready = 1'b0;
        req = 8'b0001_0000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_v",   32'(grant_valid), 1);
            chk("stall_idx", 32'(grant_idx), 4);
            chk("stall_p",   32'(ptr), 3);
            if (i == 1) req = 8'h00;
        end
        grant_ready = 1'b1;
        step(); chk("stall_rel_v", 32'(grant_valid), 0); chk("stall_rel_p", 32'(ptr), 5);

        // Pointer wrap: grant 6, then 7, then 0.
        req = 8'b0100_0000;
        step(); chk("wrap_idx6", 32'(grant_idx), 6); chk("wrap_p5", 32'(ptr), 5);
        req = 8'b1000_0001;
        step(); chk("wrap_idx7", 32'(grant_idx), 7); chk("wrap_p7", 32'(ptr), 7);
        step(); chk("wrap_idx0", 32'(grant_idx), 0); chk("wrap_p0", 32'(ptr), 0);
        req = 8'h00;
        step(); chk("wrap_end_v", 32'(grant_valid), 0); chk("wrap_end_p", 32'(ptr), 1);

        // Asynchronous reset in the middle of an outstanding grant.
        grant_ready = 1'b0;
        req = 8'b0010_0000;
        step(); chk("ar_idx5", 32'(grant_idx), 5); chk("ar_v", 32'(grant_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_now_v",   32'(grant_valid), 0);
        chk("ar_now_p",   32'(ptr), 0);
        chk("ar_now_idx", 32'(grant_idx), 0);
        req = 8'b0010_0001;
        @(negedge clk);
        rst = 1'b0;
        step(); chk("ar_first_idx", 32'(grant_idx), 0); chk("ar_first_v", 32'(grant_valid), 1); chk("ar_first_p", 32'(ptr), 0);

        // All requesters, random ready: strict rotation, one-hot decode matches.
        req = 8'hFF;
        exp_idx = 3'd0;
        seen = 8'h00;
        hs = 0;
        cyc = 0;
        while (hs < 16 && cyc < 300) begin
            chk("all_v",   32'(grant_valid), 1);
            chk("all_idx", 32'(grant_idx), 32'(exp_idx));
            chk("all_p",   32'(ptr), 32'(exp_idx));
            onehot = 8'h01 << grant_idx;
            chk("all_onehot", 32'(onehot), 32'(8'h01 << exp_idx));
            rdy = 1'($urandom_range(0, 1));
            grant_ready = rdy;
            if (rdy) begin
                seen = seen | onehot;
                hs++;
                if (hs % 8 == 0) begin
                    chk("all_fair", 32'(seen), 32'hFF);
                    seen = 8'h00;
                end
            end
            step();
            cyc++;
            if (rdy) exp_idx = exp_idx + 3'd1;
        end
        chk("all_hs_count", 32'(hs), 16);

        grant_ready = 1'b0;
        req = 8'h00;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
